// File: rtl/conv_mac_engine.sv
// -----------------------------------------------------------------------------
// conv_mac_engine
//
// Convolution multiply-accumulate engine. A start request in IDLE streams
// NUM_CH*KERNEL_SIZE*KERNEL_SIZE taps from a window SRAM and a kernel SRAM.
// Both SRAMs have a one-cycle read latency. The engine accumulates the signed
// products. It then arithmetic-right-shifts the sum, optionally clamps negative
// values to zero (ReLU), and saturates to DATA_WIDTH. One result is presented
// with a single-cycle valid pulse.
//
// Ports
//   i_clk       clock, all state on the rising edge
//   i_rst       asynchronous active-high reset
//   i_start     start request, only honoured in IDLE
//   i_win_base  window start address, captured at start
//   i_shift     arithmetic right-shift amount, captured at start
//   i_relu      1 = clamp negative results to 0, captured at start
//   o_win_addr  window SRAM read address
//   o_win_rd    window SRAM read enable
//   i_win_data  window SRAM data, one cycle after o_win_rd
//   o_ker_addr  kernel SRAM read address (tap index)
//   o_ker_rd    kernel SRAM read enable, identical to o_win_rd
//   i_ker_data  kernel SRAM data, one cycle after o_ker_rd
//   o_result    saturated signed result, held until the next result
//   o_acc       raw accumulator at completion, held like o_result
//   o_valid     one-cycle pulse when o_result/o_acc update
//   o_busy      high from the start edge until the end of the valid cycle
// -----------------------------------------------------------------------------
module conv_mac_engine #(
  parameter int KERNEL_SIZE = 3,
  parameter int NUM_CH      = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 20,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic [ADDR_WIDTH-1:0]        i_win_base,
  input  logic [$clog2(ACC_WIDTH)-1:0] i_shift,
  input  logic                         i_relu,
  output logic [ADDR_WIDTH-1:0]        o_win_addr,
  output logic                         o_win_rd,
  input  logic [DATA_WIDTH-1:0]        i_win_data,
  output logic [ADDR_WIDTH-1:0]        o_ker_addr,
  output logic                         o_ker_rd,
  input  logic [DATA_WIDTH-1:0]        i_ker_data,
  output logic [DATA_WIDTH-1:0]        o_result,
  output logic [ACC_WIDTH-1:0]         o_acc,
  output logic                         o_valid,
  output logic                         o_busy
);

  localparam int SHIFT_WIDTH = $clog2(ACC_WIDTH);
  localparam int NUM_TAPS    = NUM_CH * KERNEL_SIZE * KERNEL_SIZE;
  localparam int IDX_WIDTH   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PROD_WIDTH  = 2 * DATA_WIDTH;

  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_TAPS - 1);
  localparam logic [IDX_WIDTH-1:0]  IDX_ONE  = IDX_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  // Saturation bounds of a DATA_WIDTH signed value, expressed at accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]                   state_r;
  logic [IDX_WIDTH-1:0]         idx_r;
  logic [SHIFT_WIDTH-1:0]       shift_r;
  logic                         relu_r;
  logic                         mac_en_r;
  logic signed [ACC_WIDTH-1:0]  acc_r;

  logic                         start_s;
  logic signed [PROD_WIDTH-1:0] prod_s;
  logic signed [ACC_WIDTH-1:0]  prod_ext_s;
  logic signed [ACC_WIDTH-1:0]  shifted_s;
  logic [DATA_WIDTH-1:0]        result_s;

  // ReLU first, then clamp into the signed DATA_WIDTH range.
  function automatic logic [DATA_WIDTH-1:0] relu_sat(
    input logic signed [ACC_WIDTH-1:0] value,
    input logic                        relu_en
  );
    logic signed [ACC_WIDTH-1:0] v;
    logic [DATA_WIDTH-1:0]       r;
    if (relu_en && value[ACC_WIDTH-1]) begin
      v = '0;
    end else begin
      v = value;
    end
    if (v > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (v < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = v[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  assign start_s    = (state_r == S_IDLE) && i_start;
  assign prod_s     = $signed(i_win_data) * $signed(i_ker_data);
  // The size cast sign-extends the full-precision product to accumulator width.
  assign prod_ext_s = ACC_WIDTH'(prod_s);
  assign shifted_s  = acc_r >>> shift_r;
  assign result_s   = relu_sat(shifted_s, relu_r);

  // Sequencer: state, tap counter, SRAM addresses/enables and busy flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= S_IDLE;
      idx_r      <= '0;
      o_win_addr <= '0;
      o_ker_addr <= '0;
      o_win_rd   <= 1'b0;
      o_ker_rd   <= 1'b0;
      o_busy     <= 1'b0;
      shift_r    <= '0;
      relu_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // Busy tracks the start request here.
          // Busy therefore stays high through a back-to-back restart.
          o_busy <= i_start;
          if (i_start) begin
            state_r    <= S_FETCH;
            idx_r      <= '0;
            o_win_addr <= i_win_base;
            o_ker_addr <= '0;
            o_win_rd   <= 1'b1;
            o_ker_rd   <= 1'b1;
            shift_r    <= i_shift;
            relu_r     <= i_relu;
          end else begin
            o_win_rd   <= 1'b0;
            o_ker_rd   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (idx_r == LAST_IDX) begin
            state_r  <= S_DRAIN;
            o_win_rd <= 1'b0;
            o_ker_rd <= 1'b0;
          end else begin
            // The window address wraps naturally at 2^ADDR_WIDTH.
            idx_r      <= idx_r + IDX_ONE;
            o_win_addr <= o_win_addr + ADDR_ONE;
            o_ker_addr <= o_ker_addr + ADDR_ONE;
            o_win_rd   <= 1'b1;
            o_ker_rd   <= 1'b1;
          end
        end
        S_DRAIN: begin
          state_r <= S_FINISH;
        end
        S_FINISH: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          o_win_rd <= 1'b0;
          o_ker_rd <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator: cleared on start, adds one product per cycle of returned read data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mac_en_r <= 1'b0;
      acc_r    <= '0;
    end else begin
      // Read data arrives one cycle after the enable, so the enable is delayed to qualify it.
      mac_en_r <= o_win_rd;
      if (start_s) begin
        acc_r <= '0;
      end else if (mac_en_r) begin
        acc_r <= acc_r + prod_ext_s;
      end else begin
        acc_r <= acc_r;
      end
    end
  end

  // Result registers: capture the post-processed accumulator at the end of FINISH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result <= '0;
      o_acc    <= '0;
      o_valid  <= 1'b0;
    end else if (state_r == S_FINISH) begin
      o_result <= result_s;
      o_acc    <= acc_r;
      o_valid  <= 1'b1;
    end else begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
module tb_conv_mac_engine;

  localparam int N1    = 9;
  localparam int N2    = 18;
  localparam int ACCW1 = 20;
  localparam int ACCW2 = 21;

  logic clk = 1'b0;
  logic rst;
  logic start1, start2;
  logic [7:0] win_base;
  logic [4:0] shift;
  logic       relu;

  logic [7:0] waddr1, kaddr1, wdata1 = 8'd0, kdata1 = 8'd0, res1;
  logic       wrd1, krd1, valid1, busy1;
  logic signed [ACCW1-1:0] acc1;
  logic [7:0] waddr2, kaddr2, wdata2 = 8'd0, kdata2 = 8'd0, res2;
  logic       wrd2, krd2, valid2, busy2;
  logic signed [ACCW2-1:0] acc2;

  logic [7:0] win_mem [256];
  logic [7:0] ker_mem [256];

  int checks   = 0;
  int failures = 0;
  int sel      = 0;

  logic [7:0]  obs_waddr, obs_kaddr, obs_res;
  logic        obs_wrd, obs_krd, obs_valid, obs_busy;
  logic [31:0] obs_acc;

  int waddr_q[$];
  int kaddr_q[$];

  always #5 clk = ~clk;

  conv_mac_engine #(.KERNEL_SIZE(3), .NUM_CH(1), .DATA_WIDTH(8), .ACC_WIDTH(ACCW1), .ADDR_WIDTH(8)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_win_base(win_base), .i_shift(shift),
    .i_relu(relu), .o_win_addr(waddr1), .o_win_rd(wrd1), .i_win_data(wdata1),
    .o_ker_addr(kaddr1), .o_ker_rd(krd1), .i_ker_data(kdata1), .o_result(res1),
    .o_acc(acc1), .o_valid(valid1), .o_busy(busy1));

  conv_mac_engine #(.KERNEL_SIZE(3), .NUM_CH(2), .DATA_WIDTH(8), .ACC_WIDTH(ACCW2), .ADDR_WIDTH(8)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_win_base(win_base), .i_shift(shift),
    .i_relu(relu), .o_win_addr(waddr2), .o_win_rd(wrd2), .i_win_data(wdata2),
    .o_ker_addr(kaddr2), .o_ker_rd(krd2), .i_ker_data(kdata2), .o_result(res2),
    .o_acc(acc2), .o_valid(valid2), .o_busy(busy2));

  // Synchronous-read SRAM models, one cycle latency.
  always @(posedge clk) begin
    if (wrd1) wdata1 <= win_mem[waddr1];
    if (krd1) kdata1 <= ker_mem[kaddr1];
    if (wrd2) wdata2 <= win_mem[waddr2];
    if (krd2) kdata2 <= ker_mem[kaddr2];
  end

  always_comb begin
    if (sel == 1) begin
      obs_waddr = waddr2; obs_kaddr = kaddr2; obs_wrd = wrd2; obs_krd = krd2;
      obs_res = res2; obs_valid = valid2; obs_busy = busy2; obs_acc = 32'(acc2);
    end else begin
      obs_waddr = waddr1; obs_kaddr = kaddr1; obs_wrd = wrd1; obs_krd = krd1;
      obs_res = res1; obs_valid = valid1; obs_busy = busy1; obs_acc = 32'(acc1);
    end
  end

  // Reference: dot product of window (base-relative, wrapping) and kernel, wrapped to aw bits.
  function automatic int model_acc(input int n, input int aw, input int base);
    int sum = 0;
    for (int i = 0; i < n; i++)
      sum = sum + $signed(win_mem[(base + i) % 256]) * $signed(ker_mem[i]);
    sum = (sum <<< (32 - aw)) >>> (32 - aw);
    return sum;
  endfunction

  function automatic int model_res(input int acc, input int sh, input bit rl);
    int v = acc >>> sh;
    if (rl && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int addr_errors(input int n, input int base);
    int e = 0;
    if (waddr_q.size() != n || kaddr_q.size() != n) e++;
    for (int i = 0; i < waddr_q.size(); i++) if (waddr_q[i] != (base + i) % 256) e++;
    for (int i = 0; i < kaddr_q.size(); i++) if (kaddr_q[i] != i) e++;
    return e;
  endfunction

  task automatic fill(input int wv, input int kv, input bit rnd);
    for (int i = 0; i < 256; i++) begin
      win_mem[i] = rnd ? 8'($urandom) : wv[7:0];
      ker_mem[i] = rnd ? 8'($urandom) : kv[7:0];
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s == 1) start2 = v; else start1 = v;
  endtask

  // Runs one operation and records latency, outputs, addresses and busy anomalies.
  task automatic do_op(input int s, input int base, input int sh, input bit rl, input int glitch_c,
                       output int lat, output logic [31:0] acc_o, output logic [7:0] res_o,
                       output int busy_bad);
    sel = s; lat = -1; busy_bad = 0; acc_o = '0; res_o = '0;
    waddr_q.delete(); kaddr_q.delete();
    win_base = base[7:0]; shift = sh[4:0]; relu = rl;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    for (int c = 0; c < 60; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == glitch_c) begin
        set_start(s, 1'b1); win_base = 8'(base ^ 85); shift = 5'((sh + 3) % 32); relu = ~rl;
      end else if (c == glitch_c + 1) begin
        set_start(s, 1'b0); win_base = base[7:0]; shift = sh[4:0]; relu = rl;
      end
      if (obs_wrd !== obs_krd) busy_bad++;
      if (obs_wrd) begin waddr_q.push_back(int'(obs_waddr)); kaddr_q.push_back(int'(obs_kaddr)); end
      if (!obs_busy) busy_bad++;
      if (obs_valid) begin lat = c; acc_o = obs_acc; res_o = obs_res; break; end
    end
    @(posedge clk); #1;
    if (obs_busy !== 1'b0 || obs_valid !== 1'b0) busy_bad++;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      checks++;
      if ({obs_waddr, obs_kaddr, obs_wrd, obs_krd, obs_res, obs_valid, obs_busy} !== 29'd0) begin
        failures++;
        $display("FAIL reset_outs dut%0d got=%h exp=0", s + 1,
                 {obs_waddr, obs_kaddr, obs_wrd, obs_krd, obs_res, obs_valid, obs_busy});
      end
      checks++;
      if (obs_acc !== 32'd0) begin failures++; $display("FAIL reset_acc dut%0d got=%0d exp=0", s + 1, obs_acc); end
    end
  endtask

  task automatic test_single_channel();
    int lat, bb; logic [31:0] a; logic [7:0] r;
    fill(1, 1, 1'b0);
    do_op(0, 16, 0, 1'b0, -1, lat, a, r, bb);
    checks++; if (lat !== 11) begin failures++; $display("FAIL single_lat got=%0d exp=11", lat); end
    checks++; if (a !== 32'd9) begin failures++; $display("FAIL single_acc got=%0d exp=9", $signed(a)); end
    checks++; if (r !== 8'd9) begin failures++; $display("FAIL single_res got=%0d exp=9", $signed(r)); end
    checks++; if (addr_errors(9, 16) != 0) begin failures++; $display("FAIL single_addr errors=%0d exp=0", addr_errors(9, 16)); end
    checks++; if (bb != 0) begin failures++; $display("FAIL single_busy anomalies=%0d exp=0", bb); end
  endtask

  task automatic test_negative();
    int lat, bb; logic [31:0] a; logic [7:0] r;
    fill(1, -2, 1'b0);
    do_op(0, 0, 0, 1'b0, -1, lat, a, r, bb);
    checks++; if (a !== 32'hFFFF_FFEE) begin failures++; $display("FAIL neg_acc got=%0d exp=-18", $signed(a)); end
    checks++; if (r !== 8'hEE) begin failures++; $display("FAIL neg_res got=%0d exp=-18", $signed(r)); end
    do_op(0, 0, 0, 1'b1, -1, lat, a, r, bb);
    checks++; if (a !== 32'hFFFF_FFEE) begin failures++; $display("FAIL relu_acc got=%0d exp=-18", $signed(a)); end
    checks++; if (r !== 8'd0) begin failures++; $display("FAIL relu_res got=%0d exp=0", $signed(r)); end
  endtask

  task automatic test_saturation();
    int lat, bb; logic [31:0] a; logic [7:0] r;
    fill(127, 127, 1'b0);
    do_op(0, 100, 0, 1'b0, -1, lat, a, r, bb);
    checks++; if (a !== 32'd145161) begin failures++; $display("FAIL sat_acc got=%0d exp=145161", $signed(a)); end
    checks++; if (r !== 8'd127) begin failures++; $display("FAIL sat_pos got=%0d exp=127", $signed(r)); end
    do_op(0, 100, 12, 1'b0, -1, lat, a, r, bb);
    checks++; if (r !== 8'd35) begin failures++; $display("FAIL shift12 got=%0d exp=35", $signed(r)); end
    fill(-128, 127, 1'b0);
    do_op(0, 100, 0, 1'b0, -1, lat, a, r, bb);
    checks++; if (a !== 32'hFFFD_C480) begin failures++; $display("FAIL sat_neg_acc got=%0d exp=-146304", $signed(a)); end
    checks++; if (r !== 8'h80) begin failures++; $display("FAIL sat_neg got=%0d exp=-128", $signed(r)); end
  endtask

  task automatic test_multi_channel();
    int lat, bb; logic [31:0] a; logic [7:0] r;
    fill(2, 3, 1'b0);
    do_op(1, 250, 0, 1'b0, -1, lat, a, r, bb);
    checks++; if (lat !== 20) begin failures++; $display("FAIL multi_lat got=%0d exp=20", lat); end
    checks++; if (a !== 32'd108) begin failures++; $display("FAIL multi_acc got=%0d exp=108", $signed(a)); end
    checks++; if (r !== 8'd108) begin failures++; $display("FAIL multi_res got=%0d exp=108", $signed(r)); end
    checks++; if (addr_errors(18, 250) != 0) begin failures++; $display("FAIL multi_addr errors=%0d exp=0", addr_errors(18, 250)); end
    checks++; if (bb != 0) begin failures++; $display("FAIL multi_busy anomalies=%0d exp=0", bb); end
  endtask

  task automatic test_start_while_busy();
    int lat, bb, ea, er; logic [31:0] a; logic [7:0] r, er8;
    fill(0, 0, 1'b1);
    ea = model_acc(N1, ACCW1, 40); er = model_res(ea, 4, 1'b0); er8 = er[7:0];
    do_op(0, 40, 4, 1'b0, 3, lat, a, r, bb);
    checks++; if (lat !== 11) begin failures++; $display("FAIL busy_start_lat got=%0d exp=11", lat); end
    checks++; if (a !== ea) begin failures++; $display("FAIL busy_start_acc got=%0d exp=%0d", $signed(a), ea); end
    checks++; if (r !== er8) begin failures++; $display("FAIL busy_start_res got=%0d exp=%0d", $signed(r), er); end
    checks++; if (addr_errors(9, 40) != 0) begin failures++; $display("FAIL busy_start_addr errors=%0d exp=0", addr_errors(9, 40)); end
    checks++; if (bb != 0) begin failures++; $display("FAIL busy_start_busy anomalies=%0d exp=0", bb); end
  endtask

  task automatic test_back_to_back();
    int vc[$]; int bad_res = 0, bad_gap = 0, ea, er, idle_wait;
    logic [7:0] er8;
    sel = 0;
    fill(0, 0, 1'b1);
    ea = model_acc(N1, ACCW1, 7); er = model_res(ea, 2, 1'b0); er8 = er[7:0];
    win_base = 8'd7; shift = 5'd2; relu = 1'b0; start1 = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(posedge clk); #1;
      if (!obs_busy) bad_gap++;
      if (obs_valid) begin
        vc.push_back(c);
        if (obs_acc !== ea || obs_res !== er8) bad_res++;
      end
    end
    start1 = 1'b0;
    checks++; if (vc.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", vc.size()); end
    checks++;
    if (vc.size() == 0 || vc[0] != 11) begin
      failures++; $display("FAIL b2b_first got=%0d exp=11", (vc.size() == 0) ? -1 : vc[0]);
    end
    for (int i = 1; i < vc.size(); i++) if (vc[i] - vc[i-1] != 12) bad_gap++;
    checks++; if (bad_gap != 0) begin failures++; $display("FAIL b2b_spacing anomalies=%0d exp=0", bad_gap); end
    checks++; if (bad_res != 0) begin failures++; $display("FAIL b2b_results wrong=%0d exp=0", bad_res); end
    idle_wait = 0;
    while (obs_busy && idle_wait < 30) begin @(posedge clk); #1; idle_wait++; end
    checks++; if (obs_busy !== 1'b0) begin failures++; $display("FAIL b2b_idle busy=%b exp=0", obs_busy); end
  endtask

  task automatic test_reset_mid_fetch();
    int lat, bb, stray = 0; logic [31:0] a; logic [7:0] r;
    sel = 0;
    fill(1, 1, 1'b0);
    win_base = 8'd0; shift = 5'd0; relu = 1'b0; start1 = 1'b1;
    @(posedge clk); #1; start1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (obs_wrd !== 1'b1 || obs_kaddr !== 8'd4) begin
      failures++; $display("FAIL midrst_pre rd=%b kaddr=%0d exp rd=1 kaddr=4", obs_wrd, obs_kaddr);
    end
    rst = 1'b1; #1;
    checks++;
    if ({obs_waddr, obs_kaddr, obs_wrd, obs_krd, obs_res, obs_valid, obs_busy} !== 29'd0 || obs_acc !== 32'd0) begin
      failures++;
      $display("FAIL midrst_outs got=%h acc=%0d exp=0", {obs_waddr, obs_kaddr, obs_wrd, obs_krd, obs_res, obs_valid, obs_busy}, obs_acc);
    end
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (obs_valid || obs_busy) stray++;
    end
    checks++; if (stray != 0) begin failures++; $display("FAIL midrst_stray cycles=%0d exp=0", stray); end
    do_op(0, 3, 0, 1'b0, -1, lat, a, r, bb);
    checks++; if (lat !== 11) begin failures++; $display("FAIL midrst_lat got=%0d exp=11", lat); end
    checks++; if (a !== 32'd9 || r !== 8'd9) begin failures++; $display("FAIL midrst_result acc=%0d res=%0d exp=9", $signed(a), $signed(r)); end
  endtask

  task automatic test_random();
    int lat, bb, s, n, aw, base, sh, ea, er; bit rl; logic [31:0] a; logic [7:0] r, er8;
    for (int it = 0; it < 8; it++) begin
      s = it % 2; n = s ? N2 : N1; aw = s ? ACCW2 : ACCW1;
      base = $urandom_range(0, 255); sh = $urandom_range(0, 14); rl = 1'($urandom_range(0, 1));
      fill(0, 0, 1'b1);
      ea = model_acc(n, aw, base); er = model_res(ea, sh, rl); er8 = er[7:0];
      do_op(s, base, sh, rl, -1, lat, a, r, bb);
      checks++; if (lat != n + 2) begin failures++; $display("FAIL rnd%0d_lat got=%0d exp=%0d", it, lat, n + 2); end
      checks++; if (a !== ea) begin failures++; $display("FAIL rnd%0d_acc got=%0d exp=%0d", it, $signed(a), ea); end
      checks++; if (r !== er8) begin failures++; $display("FAIL rnd%0d_res got=%0d exp=%0d", it, $signed(r), er); end
      checks++; if (addr_errors(n, base) != 0) begin failures++; $display("FAIL rnd%0d_addr errors=%0d exp=0", it, addr_errors(n, base)); end
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    win_base = 8'd0; shift = 5'd0; relu = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    test_reset();
    test_single_channel();
    test_negative();
    test_saturation();
    test_multi_channel();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
